reg_file: RTL
=============

Name: reg_file

Overview:
- 32 x 32-bit integer register file for the single-cycle RISC datapath.
- Sits directly upstream of the ALU:
  - rd1 drives ALU operand A.
  - rd2 drives operand B through the immediate mux.
- Provides two combinational read ports and one synchronous write port, written from the writeback mux.
- Register x0 is hardwired to zero; an optional write-to-read bypass is available.

Parameters:
- DATA_W, 32, register and port data width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to the read port; 0 = the read returns the pre-write value.
- ZERO_REG, 1, 1 = index 0 is hardwired to zero; 0 = index 0 is an ordinary register.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  write enable for this cycle.
- rd  input  ADDR_W  destination register index.
- wd  input  DATA_W  write data from writeback.
- rs1  input  ADDR_W  read port 1 index.
- rs2  input  ADDR_W  read port 2 index.
- rd1  output  DATA_W  read data 1, to ALU A.
- rd2  output  DATA_W  read data 2, to ALU B mux.
- wr_cnt  output  8  count of committed writes, saturating at 8'hFF; used for debug and coverage.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits, flip-flop based (not inferred RAM), so asynchronous clear is possible.
- Reset:
  - When rst_n falls, all registers and wr_cnt clear to 0 immediately, independent of clk.
  - While rst_n = 0, rd1 = rd2 = 0 and writes are ignored.
- Reset release: the first write can occur at the first rising clk edge with rst_n = 1.
- Write:
  - At a rising clk edge with rst_n = 1, we = 1 and (rd != 0 or ZERO_REG = 0), reg[rd] <= wd.
  - Latency: visible on the read ports in the following cycle (and in the same cycle if bypassed, see below).
- x0 writes: with ZERO_REG = 1, a write to rd = 0 is discarded, reg[0] stays 0, and wr_cnt does not increment.
- Read ports:
  - Purely combinational from rs1/rs2; no clock latency.
  - rd1 = (ZERO_REG and rs1 = 0) ? 0 : reg[rs1]; rd2 likewise with rs2.
- Bypass (BYPASS = 1):
  - If we = 1, rd = rs1 and rd is writable (rd != 0 or ZERO_REG = 0), then rd1 = wd in the same cycle; same rule for rd2.
  - The x0 rule has priority over bypass.
- Simultaneous reads: rs1 = rs2 is legal; both ports return identical data, including the bypassed case.
- wr_cnt:
  - Increments by 1 on each committed write.
  - Holds at 8'hFF; no wrap-around.
- Reset mid-write: if rst_n asserts in the same cycle as a write, reset wins; the register stays 0 and wr_cnt stays 0.
- X-handling: unknown rs1/rs2 values may produce X on reads. we must never be X after reset.

Decomposition:
- Shared package (riscv_pkg) holds:
  - XLEN = 32.
  - REG_ADDR_W = 5.
  - REG_ZERO = 5'd0.
  - Register-name constants (e.g. REG_SP = 5'd2) for benches.
- One natural sub-module: rf_read_port. It is combinational, containing the index mux, the zero-register rule and the bypass compare, and is instantiated twice. Storage, write logic and wr_cnt stay in reg_file.

Test Plan:
1. Reset: load arbitrary values, pulse rst_n low mid-cycle (no clk edge) -> rd1 = rd2 = 0 immediately for all indices; wr_cnt = 0.
2. Basic write/read: we = 1, rd = 5, wd = 32'hDEADBEEF, one edge; then rs1 = 5, rs2 = 5 -> rd1 = rd2 = 32'hDEADBEEF; wr_cnt = 1.
3. x0 protection: we = 1, rd = 0, wd = 32'hFFFFFFFF -> rs1 = 0 reads 0, including in the same cycle; wr_cnt unchanged.
4. Bypass: reg[7] = 32'h1; then we = 1, rd = 7, wd = 32'h2, rs1 = 7, checked before the edge -> rd1 = 32'h2 when BYPASS = 1, 32'h1 when BYPASS = 0; 32'h2 after the edge in both cases.
5. Reset vs write: assert rst_n = 0 coincident with we = 1, rd = 3, wd = 32'hA5A5A5A5 -> reg[3] = 0 after release.
6. Saturation: 300 consecutive writes to rd = 1 -> wr_cnt = 8'hFF; reg[1] = last wd.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC core constants: register-file geometry and ABI register names.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd1;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;
  localparam logic [REG_ADDR_W-1:0] REG_GP   = 5'd3;
  localparam logic [REG_ADDR_W-1:0] REG_TP   = 5'd4;
  localparam logic [REG_ADDR_W-1:0] REG_T0   = 5'd5;
  localparam logic [REG_ADDR_W-1:0] REG_T2   = 5'd7;
  localparam logic [REG_ADDR_W-1:0] REG_A0   = 5'd10;

endpackage

// File: rtl/rf_read_port.sv
// Combinational register-file read port: index mux, optional write bypass, x0 forced to zero.
// Zero latency, no backpressure; the x0 rule overrides the bypass.
module rf_read_port
  import riscv_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_rdata
);

  always_comb begin
    o_rdata = i_regs[i_rs];
    if (BYPASS != 0 && i_wr_en && i_rd == i_rs) begin
      o_rdata = i_wd;
    end
    if (ZERO_REG != 0 && i_rs == '0) begin
      o_rdata = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Flop-based 2-read/1-write register file with async clear and a saturating commit counter.
// Reads are combinational, writes land on the rising edge; no backpressure.
module reg_file
  import riscv_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [7:0]        wr_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [7:0]        r_wr_cnt;
  logic              w_wr_commit;

  // Gated by rst_n so the bypass cannot leak write data while reset is held.
  assign w_wr_commit = rst_n && we && (ZERO_REG == 0 || rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_cnt <= '0;
    end else if (w_wr_commit) begin
      r_regs[rd] <= wd;
      if (r_wr_cnt != 8'hFF) begin
        r_wr_cnt <= r_wr_cnt + 8'd1;
      end
    end
  end

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_port1 (
    .i_rs   (rs1),
    .i_regs (r_regs),
    .i_wr_en(w_wr_commit),
    .i_rd   (rd),
    .i_wd   (wd),
    .o_rdata(rd1)
  );

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_port2 (
    .i_rs   (rs2),
    .i_regs (r_regs),
    .i_wr_en(w_wr_commit),
    .i_rd   (rd),
    .i_wd   (wd),
    .o_rdata(rd2)
  );

  assign wr_cnt = r_wr_cnt;

endmodule
